// File: rtl/decode_pkg.sv
// Shared decode definitions: RV32I opcodes, instruction classes, immediate formats.
package decode_pkg;

   localparam logic [6:0] OP     = 7'b0110011;
   localparam logic [6:0] OP_IMM = 7'b0010011;
   localparam logic [6:0] LOAD   = 7'b0000011;
   localparam logic [6:0] STORE  = 7'b0100011;
   localparam logic [6:0] BRANCH = 7'b1100011;
   localparam logic [6:0] JAL    = 7'b1101111;
   localparam logic [6:0] JALR   = 7'b1100111;
   localparam logic [6:0] LUI    = 7'b0110111;
   localparam logic [6:0] AUIPC  = 7'b0010111;
   localparam logic [6:0] FENCE  = 7'b0001111;
   localparam logic [6:0] SYSTEM = 7'b1110011;

   typedef enum logic [3:0] {
      CLS_OP      = 4'd0,
      CLS_OP_IMM  = 4'd1,
      CLS_LOAD    = 4'd2,
      CLS_STORE   = 4'd3,
      CLS_BRANCH  = 4'd4,
      CLS_JAL     = 4'd5,
      CLS_JALR    = 4'd6,
      CLS_LUI     = 4'd7,
      CLS_AUIPC   = 4'd8,
      CLS_FENCE   = 4'd9,
      CLS_SYSTEM  = 4'd10,
      CLS_ILLEGAL = 4'd11
   } op_class_t;

   typedef enum logic [2:0] {
      IMM_R = 3'd0,
      IMM_I = 3'd1,
      IMM_S = 3'd2,
      IMM_B = 3'd3,
      IMM_U = 3'd4,
      IMM_J = 3'd5
   } imm_fmt_t;

endpackage

// File: rtl/decode_imm_gen.sv
// Immediate generator: reassembles the RV32I immediate for a given format and
// sign-extends it to XLEN. Only instruction bits above the opcode are needed.
module imm_gen
   import decode_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:7]     instr,
   input  imm_fmt_t        fmt,
   output logic [XLEN-1:0] imm
);

   // Gather scattered immediate bits per format; signed cast performs the extension
   always_comb begin
      imm = '0;
      case (fmt)
         IMM_I:   imm = XLEN'($signed(instr[31:20]));
         IMM_S:   imm = XLEN'($signed({instr[31:25], instr[11:7]}));
         IMM_B:   imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
         IMM_U:   imm = XLEN'($signed({instr[31:12], 12'b0}));
         IMM_J:   imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
         default: imm = '0;
      endcase
   end

endmodule

// File: rtl/decode_issue.sv
// Decode/issue stage: decodes RV32I, drives register-file read addresses and
// stalls on RAW/WAW hazards using a per-register busy scoreboard.
// Optional: define DECODE_STALL_CNT_EN to add the stall_cnt output.
module decode_issue
   import decode_pkg::*;
#(
   parameter  int XLEN = 32,
   parameter  int NREG = 32,
   localparam int AW   = $clog2(NREG)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [XLEN-1:0] in_pc,
   input  logic            flush,
   output logic [AW-1:0]   read_reg1,
   output logic [AW-1:0]   read_reg2,
   input  logic [XLEN-1:0] reg_data1,
   input  logic [XLEN-1:0] reg_data2,
   input  logic            wb_en,
   input  logic [AW-1:0]   wb_addr,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output op_class_t       out_class,
   output logic [AW-1:0]   out_rd,
   output logic [2:0]      out_funct3,
   output logic            out_f7b5,
   output logic [XLEN-1:0] out_imm,
   output logic            out_wr_rd,
   output logic [XLEN-1:0] out_rs1_data,
   output logic [XLEN-1:0] out_rs2_data
`ifdef DECODE_STALL_CNT_EN
  ,output logic [31:0]     stall_cnt
`endif
);

   logic [AW-1:0]   rs1, rs2, rd;
   op_class_t       cls;
   imm_fmt_t        fmt;
   logic            use1, use2, wrd, wr_rd;
   logic [XLEN-1:0] imm;
   logic [NREG-1:0] busy, busy_nxt;
   logic [AW-1:0]   held_rs1, held_rs2;
   logic            hazard, accept;

   assign rs1 = in_instr[19:15];
   assign rs2 = in_instr[24:20];
   assign rd  = in_instr[11:7];

   // Classify the incoming opcode and pick its immediate format and register usage
   always_comb begin
      cls = CLS_ILLEGAL;
      fmt = IMM_R;
      case (in_instr[6:0])
         OP:      begin cls = CLS_OP;     fmt = IMM_R; end
         OP_IMM:  begin cls = CLS_OP_IMM; fmt = IMM_I; end
         LOAD:    begin cls = CLS_LOAD;   fmt = IMM_I; end
         STORE:   begin cls = CLS_STORE;  fmt = IMM_S; end
         BRANCH:  begin cls = CLS_BRANCH; fmt = IMM_B; end
         JAL:     begin cls = CLS_JAL;    fmt = IMM_J; end
         JALR:    begin cls = CLS_JALR;   fmt = IMM_I; end
         LUI:     begin cls = CLS_LUI;    fmt = IMM_U; end
         AUIPC:   begin cls = CLS_AUIPC;  fmt = IMM_U; end
         FENCE:   begin cls = CLS_FENCE;  fmt = IMM_I; end
         SYSTEM:  begin cls = CLS_SYSTEM; fmt = IMM_I; end
         default: begin cls = CLS_ILLEGAL; fmt = IMM_R; end
      endcase
      use1 = !(cls inside {CLS_LUI, CLS_AUIPC, CLS_JAL, CLS_ILLEGAL});
      use2 = cls inside {CLS_OP, CLS_STORE, CLS_BRANCH};
      wrd  = !(cls inside {CLS_STORE, CLS_BRANCH, CLS_FENCE, CLS_SYSTEM, CLS_ILLEGAL});
   end

   assign wr_rd = wrd && (rd != '0);

   imm_gen #(.XLEN(XLEN)) u_imm (
      .instr (in_instr[31:7]),
      .fmt   (fmt),
      .imm   (imm)
   );

   // A same-cycle writeback resolves the hazard: the regfile writes on the
   // falling edge, ahead of the next read edge.
   always_comb begin
      hazard = (use1 && busy[rs1] && !(wb_en && wb_addr == rs1)) ||
               (use2 && busy[rs2] && !(wb_en && wb_addr == rs2)) ||
               (wrd  && busy[rd]  && !(wb_en && wb_addr == rd));
   end

   assign in_ready = (!out_valid || out_ready) && !hazard && !flush;
   assign accept   = in_valid && in_ready;

   // Keep reading the held instruction's sources while stalled so reg_data stays aligned
   assign read_reg1 = accept ? rs1 : held_rs1;
   assign read_reg2 = accept ? rs2 : held_rs2;

   assign out_rs1_data = reg_data1;
   assign out_rs2_data = reg_data2;

   // Scoreboard next state: writeback clear, flush clear, then accept set (set wins)
   always_comb begin
      busy_nxt = busy;
      if (wb_en) busy_nxt[wb_addr] = 1'b0;
      if (flush && out_valid && out_wr_rd) busy_nxt[out_rd] = 1'b0;
      if (accept && wr_rd) busy_nxt[rd] = 1'b1;
      busy_nxt[0] = 1'b0;
   end

   // Busy scoreboard register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) busy <= '0;
      else        busy <= busy_nxt;
   end

   // Output stage: latch decoded fields on accept, drop valid on consume or flush
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         out_pc     <= '0;
         out_class  <= CLS_OP;
         out_rd     <= '0;
         out_funct3 <= '0;
         out_f7b5   <= 1'b0;
         out_imm    <= '0;
         out_wr_rd  <= 1'b0;
         held_rs1   <= '0;
         held_rs2   <= '0;
      end else if (accept) begin
         out_valid  <= 1'b1;
         out_pc     <= in_pc;
         out_class  <= cls;
         out_rd     <= rd;
         out_funct3 <= in_instr[14:12];
         out_f7b5   <= in_instr[30];
         out_imm    <= imm;
         out_wr_rd  <= wr_rd;
         held_rs1   <= rs1;
         held_rs2   <= rs2;
      end else if (flush || out_ready) begin
         out_valid  <= 1'b0;
      end
   end

`ifdef DECODE_STALL_CNT_EN
   // Count cycles where fetch offers work that the scoreboard holds back
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                           stall_cnt <= '0;
      else if (in_valid && hazard && !flush) stall_cnt <= stall_cnt + 32'd1;
   end
`endif

endmodule

// File: tb/tb_decode_issue.sv
// Self-checking bench for decode_issue: directed scenarios followed by random
// traffic, all compared against a behavioural model of the stage.
module tb_decode_issue;
   import decode_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, flush, wb_en, out_valid, out_ready;
   logic [31:0] in_instr, in_pc, reg_data1, reg_data2;
   logic [4:0]  read_reg1, read_reg2, wb_addr, out_rd;
   logic [31:0] out_pc, out_imm, out_rs1_data, out_rs2_data;
   op_class_t   out_class;
   logic [2:0]  out_funct3;
   logic        out_f7b5, out_wr_rd;
`ifdef DECODE_STALL_CNT_EN
   logic [31:0] stall_cnt;
`endif

   int checks = 0;
   int errors = 0;

   // model state
   logic [31:0] m_busy;
   bit          m_valid;
   logic [31:0] m_instr, m_pc, m_cnt;

   decode_issue dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
      .read_reg1(read_reg1), .read_reg2(read_reg2),
      .reg_data1(reg_data1), .reg_data2(reg_data2),
      .wb_en(wb_en), .wb_addr(wb_addr),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
      .out_class(out_class), .out_rd(out_rd), .out_funct3(out_funct3),
      .out_f7b5(out_f7b5), .out_imm(out_imm), .out_wr_rd(out_wr_rd),
      .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data)
`ifdef DECODE_STALL_CNT_EN
     ,.stall_cnt(stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic op_class_t cls_of(input logic [31:0] i);
      case (i[6:0])
         7'b0110011: return CLS_OP;
         7'b0010011: return CLS_OP_IMM;
         7'b0000011: return CLS_LOAD;
         7'b0100011: return CLS_STORE;
         7'b1100011: return CLS_BRANCH;
         7'b1101111: return CLS_JAL;
         7'b1100111: return CLS_JALR;
         7'b0110111: return CLS_LUI;
         7'b0010111: return CLS_AUIPC;
         7'b0001111: return CLS_FENCE;
         7'b1110011: return CLS_SYSTEM;
         default:    return CLS_ILLEGAL;
      endcase
   endfunction

   function automatic bit reads1(input op_class_t c);
      return !(c == CLS_LUI || c == CLS_AUIPC || c == CLS_JAL || c == CLS_ILLEGAL);
   endfunction
   function automatic bit reads2(input op_class_t c);
      return c == CLS_OP || c == CLS_STORE || c == CLS_BRANCH;
   endfunction
   function automatic bit writes(input op_class_t c);
      return !(c == CLS_STORE || c == CLS_BRANCH || c == CLS_FENCE || c == CLS_SYSTEM || c == CLS_ILLEGAL);
   endfunction
   function automatic bit wr_of(input logic [31:0] i);
      return writes(cls_of(i)) && i[11:7] != 5'd0;
   endfunction

   // Reference immediate built with arithmetic shifts on the whole word
   function automatic logic [31:0] imm_of(input logic [31:0] i);
      logic [31:0] s;
      op_class_t   c;
      c = cls_of(i);
      case (c)
         CLS_OP_IMM, CLS_LOAD, CLS_JALR, CLS_FENCE, CLS_SYSTEM:
            s = 32'($signed(i) >>> 20);
         CLS_STORE:
            s = (32'($signed(i) >>> 25) << 5) | 32'(i[11:7]);
         CLS_BRANCH:
            s = (32'($signed(i) >>> 31) << 12) | (32'(i[7]) << 11) | (32'(i[30:25]) << 5) | (32'(i[11:8]) << 1);
         CLS_LUI, CLS_AUIPC:
            s = i & 32'hFFFF_F000;
         CLS_JAL:
            s = (32'($signed(i) >>> 31) << 20) | (32'(i[19:12]) << 12) | (32'(i[20]) << 11) | (32'(i[30:21]) << 1);
         default:
            s = 32'd0;
      endcase
      return s;
   endfunction

   task automatic model_reset();
      m_busy = '0; m_valid = 0; m_instr = '0; m_pc = '0; m_cnt = '0;
   endtask

   // One clock: inputs are already driven; check at the falling edge, advance model, return at posedge+1
   task automatic cycle();
      op_class_t   c;
      logic [4:0]  s1, s2, d;
      bit          hz, rdy, acc;
      logic [31:0] nb;
      reg_data1 = $urandom;
      reg_data2 = $urandom;
      @(negedge clk);
      c  = cls_of(in_instr);
      s1 = in_instr[19:15]; s2 = in_instr[24:20]; d = in_instr[11:7];
      hz = (reads1(c) && m_busy[s1] && !(wb_en && wb_addr == s1)) ||
           (reads2(c) && m_busy[s2] && !(wb_en && wb_addr == s2)) ||
           (writes(c) && m_busy[d]  && !(wb_en && wb_addr == d));
      rdy = (!m_valid || out_ready) && !hz && !flush;
      acc = in_valid && rdy;
      chk("in_ready", in_ready, rdy);
      chk("read_reg1", read_reg1, acc ? s1 : m_instr[19:15]);
      chk("read_reg2", read_reg2, acc ? s2 : m_instr[24:20]);
      chk("out_valid", out_valid, m_valid);
      chk("busy", dut.busy, m_busy);
      chk("rs1_data", out_rs1_data, reg_data1);
      chk("rs2_data", out_rs2_data, reg_data2);
      if (m_valid) begin
         chk("out_pc", out_pc, m_pc);
         chk("out_class", out_class, cls_of(m_instr));
         chk("out_rd", out_rd, m_instr[11:7]);
         chk("out_funct3", out_funct3, m_instr[14:12]);
         chk("out_f7b5", out_f7b5, m_instr[30]);
         chk("out_imm", out_imm, imm_of(m_instr));
         chk("out_wr_rd", out_wr_rd, wr_of(m_instr));
      end
`ifdef DECODE_STALL_CNT_EN
      chk("stall_cnt", stall_cnt, m_cnt);
`endif
      nb = m_busy;
      if (wb_en) nb[wb_addr] = 1'b0;
      if (flush && m_valid && wr_of(m_instr)) nb[m_instr[11:7]] = 1'b0;
      if (acc && wr_of(in_instr)) nb[d] = 1'b1;
      if (in_valid && hz && !flush) m_cnt = m_cnt + 32'd1;
      if (acc) begin
         m_valid = 1; m_instr = in_instr; m_pc = in_pc;
      end else if (flush || out_ready) begin
         m_valid = 0;
      end
      m_busy = nb;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_all();
      in_valid = 0; out_ready = 1; flush = 0;
      for (int r = 1; r < 32; r++) begin
         wb_en = 1; wb_addr = 5'(r);
         cycle();
      end
      wb_en = 0;
   endtask

   localparam logic [31:0] ADDI_X1_5  = 32'h0050_0093;
   localparam logic [31:0] ADD_X2_X1  = 32'h0010_8133;
   localparam logic [31:0] ADDI_X7_1  = 32'h0010_0393;
   localparam logic [31:0] LW_X5_M4   = 32'hFFC1_A283;
   localparam logic [31:0] ADD_X0     = 32'h0000_0033;
   localparam logic [31:0] ADD_X3_X0  = 32'h0000_01B3;

   initial begin
      logic [31:0] cnt0;
      logic [6:0]  opcs [12];
      opcs = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111,
               7'b1100111, 7'b0110111, 7'b0010111, 7'b0001111, 7'b1110011, 7'b1111111};

      // reset
      rst_n = 0; in_valid = 0; in_instr = '0; in_pc = '0; flush = 0;
      reg_data1 = '0; reg_data2 = '0; wb_en = 0; wb_addr = '0; out_ready = 0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_imm", out_imm, 0);
      chk("rst_out_class", out_class, 0);
      chk("rst_out_pc", out_pc, 0);
      chk("rst_read_reg1", read_reg1, 0);
      chk("rst_busy", dut.busy, 0);
`ifdef DECODE_STALL_CNT_EN
      chk("rst_stall_cnt", stall_cnt, 0);
`endif
      rst_n = 1;

      // addi x1,x0,5
      in_valid = 1; in_instr = ADDI_X1_5; in_pc = 32'h100; out_ready = 0;
      cycle();
      chk("addi_valid", out_valid, 1);
      chk("addi_imm", out_imm, 5);
      chk("addi_rd", out_rd, 1);
      chk("addi_wr_rd", out_wr_rd, 1);
      chk("addi_busy1", dut.busy[1], 1);

      // RAW on x1, released by same-cycle writeback
      in_instr = ADD_X2_X1; in_pc = 32'h104; out_ready = 1;
      #1 chk("raw_stall_ready", in_ready, 0);
      cycle();
      chk("raw_held_ready", in_ready, 0);
      wb_en = 1; wb_addr = 5'd1;
      #1 chk("raw_wb_ready", in_ready, 1);
      cycle();
      wb_en = 0;
      chk("raw_busy1", dut.busy[1], 0);
      chk("raw_busy2", dut.busy[2], 1);
      chk("raw_out_rd", out_rd, 2);

      // backpressure: held instruction keeps driving read addresses
      in_instr = ADDI_X7_1; in_pc = 32'h108; out_ready = 0;
      repeat (3) begin
         cycle();
         chk("bp_read_reg1", read_reg1, 1);
         chk("bp_read_reg2", read_reg2, 1);
         chk("bp_ready", in_ready, 0);
         chk("bp_out_pc", out_pc, 32'h104);
      end
      out_ready = 1;
      cycle();

      // flush a held load
      in_instr = LW_X5_M4; in_pc = 32'h10C;
      cycle();
      in_valid = 0; out_ready = 0;
      #1;
      chk("ld_imm", out_imm, 32'hFFFF_FFFC);
      chk("ld_busy5", dut.busy[5], 1);
      flush = 1;
      #1 chk("flush_ready", in_ready, 0);
      cycle();
      flush = 0;
      chk("flush_valid", out_valid, 0);
      chk("flush_busy5", dut.busy[5], 0);

      // x0 destination never stalls
      clear_all();
      in_valid = 1; out_ready = 1; in_instr = ADD_X0; in_pc = 32'h200;
      cycle();
      in_instr = ADD_X3_X0; in_pc = 32'h204;
      #1 chk("x0_ready", in_ready, 1);
      cycle();
      chk("x0_busy0", dut.busy[0], 0);
      chk("x0_out_rd", out_rd, 3);

      // 4-cycle RAW stall, then asynchronous reset mid-stall
      clear_all();
      in_valid = 1; out_ready = 0; in_instr = ADDI_X1_5; in_pc = 32'h300;
      cycle();
      in_instr = ADD_X2_X1; in_pc = 32'h304;
      cnt0 = m_cnt;
      repeat (4) cycle();
`ifdef DECODE_STALL_CNT_EN
      chk("stall4", stall_cnt, cnt0 + 32'd4);
`else
      chk("stall4_model", m_cnt, cnt0 + 32'd4);
`endif
      #2 rst_n = 0;
      #1;
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_busy", dut.busy, 0);
`ifdef DECODE_STALL_CNT_EN
      chk("mid_rst_cnt", stall_cnt, 0);
`endif
      model_reset();
      in_valid = 0;
      @(posedge clk);
      #1 rst_n = 1;

      // random traffic
      for (int n = 0; n < 600; n++) begin
         logic [31:0] w;
         w = $urandom;
         w[6:0]   = opcs[$urandom_range(0, 11)];
         w[11:7]  = 5'($urandom_range(0, 7));
         w[19:15] = 5'($urandom_range(0, 7));
         w[24:20] = 5'($urandom_range(0, 7));
         in_instr  = w;
         in_pc     = $urandom;
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         flush     = ($urandom_range(0, 9) == 0);
         wb_en     = ($urandom_range(0, 4) < 2);
         wb_addr   = 5'($urandom_range(0, 7));
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
